// File: rtl/mem_line_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_line_pkg
// Description : Shared types and constants for the cache-line memory master.
//               Holds the burst FSM state encoding, the default memory
//               geometry and a helper that turns the line-offset width into
//               the number of words per line.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_line_pkg;

  localparam int c_DEF_ADDR_LEN      = 11;
  localparam int c_DEF_LINE_ADDR_LEN = 3;
  localparam int c_WORD_W            = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Number of words in a line given log2 of the line size.
  function automatic int line_words(input int line_addr_len);
    return 1 << line_addr_len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_line_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_line_master
// Description : Converts one cache line-fill or line-writeback request into a
//               burst of single-word accesses on a synchronous word memory
//               with a 1-cycle registered read. Reads are pipelined: each
//               cycle presents a new address while capturing the data of the
//               previous one.
// Ports       : clk, rst (async, active low)
//               req_*  : request handshake from the cache controller
//               resp_* : one-cycle completion pulse + assembled read line
//               mem_*  : word-memory port (address, write strobe/data,
//                        read data returned one cycle after its address)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_line_master
  import mem_line_pkg::*;
#(
  parameter  int ADDR_LEN      = c_DEF_ADDR_LEN,
  parameter  int LINE_ADDR_LEN = c_DEF_LINE_ADDR_LEN,
  localparam int c_LINE_WORDS  = line_words(LINE_ADDR_LEN),
  localparam int c_LINE_IDX_W  = ADDR_LEN - LINE_ADDR_LEN
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_wr,
  input  logic [c_LINE_IDX_W-1:0]          req_line_addr,
  input  logic [c_WORD_W*c_LINE_WORDS-1:0] req_wdata,
  output logic                             resp_valid,
  output logic [c_WORD_W*c_LINE_WORDS-1:0] resp_rdata,
  output logic [ADDR_LEN-1:0]              mem_addr,
  output logic                             mem_wr_req,
  output logic [c_WORD_W-1:0]              mem_wr_data,
  input  logic [c_WORD_W-1:0]              mem_rd_data
);

  localparam logic [LINE_ADDR_LEN-1:0] c_LAST_WORD = {LINE_ADDR_LEN{1'b1}};
  localparam logic [LINE_ADDR_LEN-1:0] c_FIRST_WORD = '0;

  state_e                                   state_q, state_d;
  logic [LINE_ADDR_LEN-1:0]                 cnt_q, cnt_d;
  logic [c_LINE_IDX_W-1:0]                  line_q, line_d;
  logic [c_LINE_WORDS-1:0][c_WORD_W-1:0]    wdata_q, wdata_d;
  logic [c_LINE_WORDS-1:0][c_WORD_W-1:0]    rdata_q, rdata_d;
  logic                                     req_ready_q, req_ready_d;
  logic                                     resp_valid_q, resp_valid_d;
  logic [ADDR_LEN-1:0]                      mem_addr_q, mem_addr_d;
  logic                                     mem_wr_req_q, mem_wr_req_d;
  logic [c_WORD_W-1:0]                      mem_wr_data_q, mem_wr_data_d;

  // Read data arriving now belongs to the address presented one cycle ago.
  logic [LINE_ADDR_LEN-1:0]                 w_cap_idx;
  assign w_cap_idx = cnt_q - 1'b1;

  // All outputs are registered: the _d values describe what the memory port
  // should show during the cycle that follows the next clock edge.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    line_d        = line_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    req_ready_d   = req_ready_q;
    resp_valid_d  = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_req_d  = mem_wr_req_q;
    mem_wr_data_d = mem_wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          line_d      = req_line_addr;
          wdata_d     = req_wdata;
          cnt_d       = c_FIRST_WORD;
          req_ready_d = 1'b0;
          mem_addr_d  = {req_line_addr, c_FIRST_WORD};
          if (req_wr) begin
            state_d       = ST_WRITE;
            mem_wr_req_d  = 1'b1;
            mem_wr_data_d = req_wdata[c_WORD_W-1:0];
          end else begin
            state_d = ST_READ;
          end
        end
      end

      ST_WRITE: begin
        if (cnt_q == c_LAST_WORD) begin
          state_d       = ST_DONE;
          resp_valid_d  = 1'b1;
          mem_wr_req_d  = 1'b0;
          mem_addr_d    = '0;
          mem_wr_data_d = '0;
        end else begin
          cnt_d         = cnt_q + 1'b1;
          mem_addr_d    = {line_q, cnt_d};
          mem_wr_data_d = wdata_q[cnt_d];
        end
      end

      ST_READ: begin
        if (cnt_q != c_FIRST_WORD) begin
          rdata_d[w_cap_idx] = mem_rd_data;
        end
        if (cnt_q == c_LAST_WORD) begin
          state_d    = ST_DRAIN;
          mem_addr_d = '0;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          mem_addr_d = {line_q, cnt_d};
        end
      end

      // Last address was issued in the final READ cycle; its data lands now.
      ST_DRAIN: begin
        rdata_d[c_LAST_WORD] = mem_rd_data;
        state_d              = ST_DONE;
        resp_valid_d         = 1'b1;
      end

      ST_DONE: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d       = ST_IDLE;
        req_ready_d   = 1'b1;
        mem_wr_req_d  = 1'b0;
        mem_addr_d    = '0;
        mem_wr_data_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      line_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_req_q  <= 1'b0;
      mem_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      line_q        <= line_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_req_q  <= mem_wr_req_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_req  = mem_wr_req_q;
  assign mem_wr_data = mem_wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_line_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_line_master
// Description : Self-checking bench for mem_line_master. Contains a word
//               memory with a 1-cycle registered read, a word-level reference
//               image of that memory, directed line reads/writes, a reset
//               in the middle of a write burst, back-to-back held requests
//               and a randomized request phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_line_master;

  localparam int c_ADDR_LEN  = 11;
  localparam int c_LA_LEN    = 3;
  localparam int c_LW        = 8;
  localparam int c_DEPTH     = 1 << c_ADDR_LEN;
  localparam int c_LINE_W    = c_ADDR_LEN - c_LA_LEN;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    req_valid = 1'b0;
  logic                    req_ready;
  logic                    req_wr = 1'b0;
  logic [c_LINE_W-1:0]     req_line_addr = '0;
  logic [32*c_LW-1:0]      req_wdata = '0;
  logic                    resp_valid;
  logic [32*c_LW-1:0]      resp_rdata;
  logic [c_ADDR_LEN-1:0]   mem_addr;
  logic                    mem_wr_req;
  logic [31:0]             mem_wr_data;
  logic [31:0]             mem_rd_data;

  logic [31:0] mem     [c_DEPTH];
  logic [31:0] ref_mem [c_DEPTH];

  int n_checks = 0;
  int n_errors = 0;
  int resp_cnt = 0;

  mem_line_master #(.ADDR_LEN(c_ADDR_LEN), .LINE_ADDR_LEN(c_LA_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_line_addr(req_line_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .mem_addr     (mem_addr),
    .mem_wr_req   (mem_wr_req),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data)
  );

  always #5 clk = ~clk;

  // Memory model plus its initial image; the reference image starts identical.
  initial begin
    logic [31:0] init_img [c_DEPTH];
    for (int i = 0; i < c_DEPTH; i++) init_img[i] = $urandom;
    init_img[0] = 32'h9d;  init_img[1] = 32'h87;  init_img[2] = 32'h83;
    init_img[3] = 32'h3a;  init_img[4] = 32'h13;  init_img[5] = 32'h48;
    init_img[6] = 32'h6a;  init_img[7] = 32'hff;
    init_img[248] = 32'h6d; init_img[249] = 32'h89; init_img[250] = 32'h4e;
    init_img[251] = 32'h9e; init_img[252] = 32'h09; init_img[253] = 32'h75;
    init_img[254] = 32'h61; init_img[255] = 32'h0a;
    init_img[32] = 32'h7f;
    init_img[20] = 32'h8a; init_img[21] = 32'h11; init_img[22] = 32'heb;
    init_img[23] = 32'h15;
    for (int i = 0; i < c_DEPTH; i++) begin
      mem[i]     = init_img[i];
      ref_mem[i] = init_img[i];
    end
    mem_rd_data = '0;
    forever begin
      @(posedge clk);
      mem_rd_data <= mem[mem_addr];
      if (mem_wr_req) mem[mem_addr] <= mem_wr_data;
    end
  end

  always @(negedge clk) if (resp_valid) resp_cnt <= resp_cnt + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] ref_line(input int line);
    logic [255:0] r;
    for (int i = 0; i < c_LW; i++) r[i*32 +: 32] = ref_mem[line*c_LW + i];
    return r;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < c_LW; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request: issue, follow the burst cycle by cycle, check the response.
  // With hold=1 req_valid stays high so the next call is accepted back-to-back.
  task automatic run_req(input bit wr, input int line, input logic [255:0] wd, input bit hold);
    int  n;
    int  lat;
    int  r0;
    bit  got;
    n = 0;
    while (!req_ready && n < 30) begin step(); n++; end
    check("accept_wait", 256'(n), 256'(0));
    req_valid     = 1'b1;
    req_wr        = wr;
    req_line_addr = c_LINE_W'(line);
    req_wdata     = wd;
    r0 = resp_cnt;
    step();  // accept edge
    if (wr) for (int i = 0; i < c_LW; i++) ref_mem[line*c_LW + i] = wd[i*32 +: 32];
    req_valid     = hold;
    req_line_addr = c_LINE_W'($urandom);
    req_wdata     = rand_line();
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 14 && !got; c++) begin
      if (c <= c_LW) begin
        check("burst_addr", 256'(mem_addr), 256'(line*c_LW + c - 1));
        check("burst_wr_req", 256'(mem_wr_req), 256'(wr));
        if (wr) check("burst_wdata", 256'(mem_wr_data), 256'(wd[(c-1)*32 +: 32]));
      end else begin
        check("tail_wr_req", 256'(mem_wr_req), 256'(0));
      end
      check("busy_ready", 256'(req_ready), 256'(0));
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
      end else begin
        step();
        req_line_addr = c_LINE_W'($urandom);
        req_wdata     = rand_line();
      end
    end
    check("latency", 256'(lat), wr ? 256'(c_LW + 1) : 256'(c_LW + 2));
    if (!wr) check("rdata", resp_rdata, ref_line(line));
    step();  // first IDLE cycle
    check("resp_once", 256'(resp_cnt - r0), 256'(1));
    check("idle_resp", 256'(resp_valid), 256'(0));
    check("idle_ready", 256'(req_ready), 256'(1));
    check("idle_addr", 256'(mem_addr), 256'(0));
  endtask

  initial begin
    logic [255:0] d;
    int r0;
    #2 rst = 1'b0;
    #10;
    check("rst_ready", 256'(req_ready), 256'(1));
    check("rst_resp", 256'(resp_valid), 256'(0));
    check("rst_rdata", resp_rdata, 256'(0));
    check("rst_addr", 256'(mem_addr), 256'(0));
    check("rst_wr_req", 256'(mem_wr_req), 256'(0));
    check("rst_wdata", 256'(mem_wr_data), 256'(0));
    @(posedge clk); #3 rst = 1'b1;
    step();

    // Directed reads of the initial image.
    run_req(1'b0, 0, rand_line(), 1'b0);
    check("line0_w0", 256'(resp_rdata[31:0]), 256'(32'h9d));
    check("line0_w7", 256'(resp_rdata[255:224]), 256'(32'hff));
    run_req(1'b0, 31, rand_line(), 1'b0);
    check("line31_w3", 256'(resp_rdata[127:96]), 256'(32'h9e));

    // Write line 5, read it back, confirm line 4 untouched.
    for (int i = 0; i < c_LW; i++) d[i*32 +: 32] = 32'hA5A50000 + i;
    run_req(1'b1, 5, d, 1'b0);
    run_req(1'b0, 5, rand_line(), 1'b0);
    check("line5_back", resp_rdata, d);
    run_req(1'b0, 4, rand_line(), 1'b0);
    check("line4_w0", 256'(resp_rdata[31:0]), 256'(32'h7f));

    // Reset after four words of a line-2 write have been stored.
    d = rand_line();
    req_valid = 1'b1; req_wr = 1'b1; req_line_addr = 8'd2; req_wdata = d;
    r0 = resp_cnt;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 4; i++) ref_mem[2*c_LW + i] = d[i*32 +: 32];
    rst = 1'b0;
    #1;
    check("rst_mid_wr_req", 256'(mem_wr_req), 256'(0));
    check("rst_mid_resp", 256'(resp_valid), 256'(0));
    @(posedge clk); @(posedge clk); #3 rst = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("rst_mid_no_resp", 256'(resp_cnt - r0), 256'(0));
    check("rst_mid_ready", 256'(req_ready), 256'(1));
    run_req(1'b0, 2, rand_line(), 1'b0);
    check("line2_w4", 256'(resp_rdata[159:128]), 256'(32'h8a));
    check("line2_w7", 256'(resp_rdata[255:224]), 256'(32'h15));

    // Held request line, alternating read/write.
    for (int k = 0; k < 6; k++)
      run_req(k[0], int'($urandom_range(0, 255)), rand_line(), 1'b1);
    req_valid = 1'b0;
    step();

    // Randomized requests.
    for (int k = 0; k < 20; k++)
      run_req(1'($urandom), int'($urandom_range(0, 255)), rand_line(), 1'($urandom));
    req_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mem_line_master.md
Name: mem_line_master

Overview:
- Initiator for the single-port synchronous word memory. The memory has a 32-bit word bus, a 1-cycle registered read and a write on the same edge as `wr_req`.
- Turns one cache line-fill (read) or line-writeback (write) request into a burst of word accesses. It runs reads pipelined, matching the memory's 1-cycle read latency.
- Sits between the cache controller and the memory model. Returns a full line and a one-cycle completion pulse.

Parameters:
- ADDR_LEN, 11, word-address width of the memory port.
- LINE_ADDR_LEN, 3, log2 of words per line; LINE_WORDS = 2**LINE_ADDR_LEN (8).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_wr  in  1  1 = line write, 0 = line read.
- req_line_addr  in  ADDR_LEN-LINE_ADDR_LEN  line index.
- req_wdata  in  32*LINE_WORDS  line to write; word i in bits [32i+31:32i].
- resp_valid  out  1  one-cycle completion pulse for the current request.
- resp_rdata  out  32*LINE_WORDS  line read; word i in bits [32i+31:32i].
- mem_addr  out  ADDR_LEN  word address = {line, word index}.
- mem_wr_req  out  1  memory write strobe.
- mem_wr_data  out  32  memory write data.
- mem_rd_data  in  32  memory read data, valid the cycle after its address was presented.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE, counters 0;
  - req_ready=1 once rst is released, resp_valid=0, resp_rdata=0;
  - mem_addr=0, mem_wr_req=0, mem_wr_data=0.
- Reset mid-burst:
  - mem_wr_req drops immediately;
  - words already written stay in memory; no resp_valid is issued.
- Accept on the rising edge where req_valid && req_ready. At that edge, register req_wr, req_line_addr and req_wdata; later input changes are ignored until IDLE.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - req_ready=1, mem_wr_req=0, mem_addr=0.
  - On accept: go to WRITE if req_wr=1, else READ; issue counter = 0.
- WRITE:
  - mem_wr_req=1, mem_addr={line,cnt}, mem_wr_data=line word cnt.
  - cnt increments every cycle; after cnt=LINE_WORDS-1 go to DONE.
  - Occupies cycles 1..LINE_WORDS after the accept edge.
- READ:
  - mem_addr={line,cnt}, mem_wr_req=0.
  - From the second READ cycle on, capture mem_rd_data into resp_rdata word cnt-1.
  - After cnt=LINE_WORDS-1 go to DRAIN.
- DRAIN: capture mem_rd_data into word LINE_WORDS-1; go to DONE.
- DONE: resp_valid=1 for exactly one cycle; req_ready=0; go to IDLE.
- Latency, counting cycles after the accept edge:
  - write: resp_valid in cycle LINE_WORDS+1 (9);
  - read: resp_valid in cycle LINE_WORDS+2 (10).
- Back-to-back: a request held high is accepted on the edge ending the first IDLE cycle after DONE. Minimum request spacing is LINE_WORDS+2 cycles for writes and LINE_WORDS+3 for reads.
- resp_rdata holds its value from read completion until the next read's captures begin; writes never modify it.
- Counter widths are LINE_ADDR_LEN bits; mem_addr is the concatenation {line, word}, with no carry into the line field.

Decomposition:
- Package mem_line_pkg holds:
  - the state enum (IDLE, WRITE, READ, DRAIN, DONE);
  - a LINE_WORDS helper constant/function;
  - default ADDR_LEN/LINE_ADDR_LEN constants.
- No sub-module. The FSM, word counter and line buffer fit flat in one module.
- Integration inverts rst for the active-high-reset memory model.

Test Plan:
- Bench: instantiate the memory model with its default initial image and check its contents through reads.
- Read line 0 -> resp_valid in cycle 10 after accept:
  - resp_rdata words 0..7 = 0x9d,0x87,0x83,0x3a,0x13,0x48,0x6a,0xff;
  - mem_wr_req stays 0 throughout.
- Read line 31 -> words = 0x6d,0x89,0x4e,0x9e,0x09,0x75,0x61,0x0a; mem_addr steps 248..255 on consecutive cycles.
- Write line 5 with word i = 0xA5A50000+i -> mem_wr_req high exactly 8 cycles (addr 40..47) and resp_valid in cycle 9. Then read line 5 -> the same 8 words; read line 4 -> word 0 = 0x7f, i.e. line 4 is untouched.
- Hold req_valid high with alternating read/write requests -> exactly one accept per IDLE cycle, resp_valid pulses exactly once per request, req_ready=0 outside IDLE.
- Assert rst low during write cycle 4 of line 2 -> mem_wr_req=0 immediately, state IDLE, no resp_valid. After release, reading line 2 returns new words 0..3 and original words 4..7 (0x8a,0x11,0xeb,0x15).
- Change req_line_addr and req_wdata mid-burst -> no effect on mem_addr/mem_wr_data; the burst completes using the values registered at accept.
